// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM states, owner
// encoding, default geometry and the timeout limit.
package mem_arb_pkg;

    localparam int ADDR_WIDTH_DEF = 10;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int LINE_WORDS_DEF = 4;
    localparam int TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two cache request channels and the data-memory port.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
);
    logic                             i_req;
    logic [ADDR_WIDTH-1:0]            i_addr;
    logic [DATA_WIDTH*LINE_WORDS-1:0] i_line;
    logic                             i_done;
    logic                             d_req;
    logic                             d_we;
    logic [ADDR_WIDTH-1:0]            d_addr;
    logic [DATA_WIDTH-1:0]            d_wdata;
    logic [DATA_WIDTH*LINE_WORDS-1:0] d_line;
    logic                             d_done;
    logic                             err;
    logic                             mem_en;
    logic                             mem_we;
    logic [ADDR_WIDTH-1:0]            mem_addr;
    logic [DATA_WIDTH-1:0]            mem_wdata;
    logic [DATA_WIDTH-1:0]            mem_rdata;
    logic                             mem_ready;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_line, i_done, d_line, d_done, err, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_line, i_done, d_line, d_done, err, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Two-requester round-robin pick. On a tie the side that did not win last
// time is chosen; the memory of the last winner moves only when grantEn_i.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   reqI_i,
    input  logic   reqD_i,
    input  logic   grantEn_i,
    output owner_e grant_o
);

    owner_e last_q;

    always_comb begin
        grant_o = OWN_I;
        if (reqD_i && !reqI_i) begin
            grant_o = OWN_D;
        end else if (reqD_i && reqI_i && (last_q == OWN_I)) begin
            grant_o = OWN_D;
        end
    end

    // Starting from "I granted last" makes D win the first tie after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= OWN_I;
        end else if (grantEn_i) begin
            last_q <= grant_o;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 32-bit memory port between icache line refills and dcache
// reads/writes. Optional ARB_TIMEOUT_EN aborts a stalled burst with err.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int LINE_W = DATA_WIDTH * LINE_WORDS;

    arb_state_e             state_q, state_d;
    owner_e                 owner_q, owner_d, grant;
    logic                   we_q, we_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic                   memEn_q, memEn_d;
    logic                   memWe_q, memWe_d;
    logic [ADDR_WIDTH-1:0]  memAddr_q, memAddr_d;
    logic [DATA_WIDTH-1:0]  memWdata_q, memWdata_d;
    logic                   iDone_q, iDone_d;
    logic                   dDone_q, dDone_d;
    logic                   err_q, err_d;
    logic [LINE_W-1:0]      iLine_q, iLine_d;
    logic [LINE_W-1:0]      dLine_q, dLine_d;
    logic                   grantEn;
    logic                   lastBeat;
    logic                   timeout;

`ifdef ARB_TIMEOUT_EN
    logic [7:0]             waitCnt_q, waitCnt_d;
    assign timeout = (waitCnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    rr_arbiter2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .reqI_i    (bus.i_req),
        .reqD_i    (bus.d_req),
        .grantEn_i (grantEn),
        .grant_o   (grant)
    );

    // Memory-port outputs are computed one cycle ahead so every output is a flop;
    // mem_addr simply steps by one per accepted beat and wraps at the top.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        beat_d     = beat_q;
        memEn_d    = memEn_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        iDone_d    = 1'b0;
        dDone_d    = 1'b0;
        err_d      = 1'b0;
        iLine_d    = iLine_q;
        dLine_d    = dLine_q;
        grantEn    = 1'b0;
        lastBeat   = we_q || (beat_q == BEAT_W'(LINE_WORDS - 1));
`ifdef ARB_TIMEOUT_EN
        waitCnt_d  = waitCnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    grantEn = 1'b1;
                    owner_d = grant;
                    beat_d  = '0;
                    state_d = BUSY;
                    memEn_d = 1'b1;
                    if (grant == OWN_D) begin
                        we_d       = bus.d_we;
                        memAddr_d  = bus.d_addr;
                        memWdata_d = bus.d_wdata;
                    end else begin
                        we_d      = 1'b0;
                        memAddr_d = bus.i_addr;
                    end
                    memWe_d = we_d;
`ifdef ARB_TIMEOUT_EN
                    waitCnt_d = '0;
`endif
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    if (!we_q) begin
                        if (owner_q == OWN_D) begin
                            dLine_d[beat_q*DATA_WIDTH +: DATA_WIDTH] = bus.mem_rdata;
                        end else begin
                            iLine_d[beat_q*DATA_WIDTH +: DATA_WIDTH] = bus.mem_rdata;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    waitCnt_d = '0;
`endif
                    if (lastBeat) begin
                        state_d = RESP;
                        memEn_d = 1'b0;
                        memWe_d = 1'b0;
                        iDone_d = (owner_q == OWN_I);
                        dDone_d = (owner_q == OWN_D);
                    end else begin
                        beat_d    = beat_q + BEAT_W'(1);
                        memAddr_d = memAddr_q + ADDR_WIDTH'(1);
                    end
                end else if (timeout) begin
                    state_d = RESP;
                    memEn_d = 1'b0;
                    memWe_d = 1'b0;
                    iDone_d = (owner_q == OWN_I);
                    dDone_d = (owner_q == OWN_D);
                    err_d   = 1'b1;
                end else begin
`ifdef ARB_TIMEOUT_EN
                    waitCnt_d = waitCnt_q + 8'd1;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_I;
            we_q       <= 1'b0;
            beat_q     <= '0;
            memEn_q    <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            iDone_q    <= 1'b0;
            dDone_q    <= 1'b0;
            err_q      <= 1'b0;
            iLine_q    <= '0;
            dLine_q    <= '0;
`ifdef ARB_TIMEOUT_EN
            waitCnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            beat_q     <= beat_d;
            memEn_q    <= memEn_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            iDone_q    <= iDone_d;
            dDone_q    <= dDone_d;
            err_q      <= err_d;
            iLine_q    <= iLine_d;
            dLine_q    <= dLine_d;
`ifdef ARB_TIMEOUT_EN
            waitCnt_q  <= waitCnt_d;
`endif
        end
    end

    assign bus.mem_en    = memEn_q;
    assign bus.mem_we    = memWe_q;
    assign bus.mem_addr  = memAddr_q;
    assign bus.mem_wdata = memWdata_q;
    assign bus.i_done    = iDone_q;
    assign bus.d_done    = dDone_q;
    assign bus.err       = err_q;
    assign bus.i_line    = iLine_q;
    assign bus.d_line    = dLine_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a memory responder plus a transaction-level model
// of arbitration order, burst addresses and assembled lines.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int LW    = 4;
    localparam int MEMSZ = 1 << AW;

    typedef struct {
        bit            isD;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) bus ();

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checkCount = 0;
    int failCount  = 0;

    logic [DW-1:0]    physMem [MEMSZ];
    logic [DW-1:0]    refMem  [MEMSZ];
    bit               memInit = 0;
    beat_t            beatLog[$];
    int               beatStart = 0;
    int               readyMode = 0;
    int               stallBudget = 0;
    int               stallUsed = 0;
    int               stabilityErrs = 0;
    logic             prevStall = 1'b0;
    logic [AW-1:0]    prevAddr;
    logic             prevWe;
    logic [DW-1:0]    prevWdata;
    bit               lastWasD = 0;
    logic [LW*DW-1:0] lastILine = '0;
    logic [LW*DW-1:0] lastDLine = '0;

    function automatic logic [DW-1:0] initWord(input int a);
        return (a * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Memory model: decides ready each cycle, presents read data and logs each accepted beat.
    always @(negedge clk) begin
        logic rdy;
        if (!memInit) begin
            for (int a = 0; a < MEMSZ; a++) physMem[a] = initWord(a);
            memInit = 1;
        end
        if (bus.mem_en && prevStall &&
            (bus.mem_addr !== prevAddr || bus.mem_we !== prevWe || bus.mem_wdata !== prevWdata))
            stabilityErrs++;
        if (bus.mem_en && stallUsed < stallBudget) begin
            rdy = 1'b0;
            stallUsed++;
        end else if (readyMode == 0) rdy = 1'b1;
        else if (readyMode == 1)     rdy = ($urandom_range(0, 99) < 60);
        else                         rdy = 1'b0;
        bus.mem_ready = rdy;
        bus.mem_rdata = physMem[bus.mem_addr];
        if (bus.mem_en && rdy) begin
            beatLog.push_back('{bus.mem_addr, bus.mem_we, bus.mem_wdata});
            if (bus.mem_we) physMem[bus.mem_addr] = bus.mem_wdata;
        end
        prevStall = bus.mem_en && !rdy;
        prevAddr  = bus.mem_addr;
        prevWe    = bus.mem_we;
        prevWdata = bus.mem_wdata;
    end

    function automatic logic [LW*DW-1:0] expectedLine(input logic [AW-1:0] base);
        logic [LW*DW-1:0] line;
        for (int k = 0; k < LW; k++) line[k*DW +: DW] = refMem[(int'(base) + k) % MEMSZ];
        return line;
    endfunction

    function automatic txn_t randTxn(input bit isD);
        txn_t t;
        t.isD   = isD;
        t.we    = isD ? 1'($urandom_range(0, 1)) : 1'b0;
        t.addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(1016, 1023))
                                              : AW'($urandom_range(0, 31));
        t.wdata = $urandom;
        return t;
    endfunction

    task automatic applyStimulus(input txn_t t);
        if (t.isD) begin
            bus.d_we    = t.we;
            bus.d_addr  = t.addr;
            bus.d_wdata = t.wdata;
            bus.d_req   = 1'b1;
        end else begin
            bus.i_addr = t.addr;
            bus.i_req  = 1'b1;
        end
    endtask

    task automatic doReset();
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst mem_en", bus.mem_en, 0);
        checkOutput("rst mem_we", bus.mem_we, 0);
        checkOutput("rst mem_addr", bus.mem_addr, 0);
        checkOutput("rst mem_wdata", bus.mem_wdata, 0);
        checkOutput("rst dones", {bus.i_done, bus.d_done, bus.err}, 0);
        checkOutput("rst i_line", bus.i_line, 0);
        checkOutput("rst d_line", bus.d_line, 0);
        reset     = 1'b0;
        lastWasD  = 0;
        lastILine = '0;
        lastDLine = '0;
        beatStart = beatLog.size();
        @(negedge clk);
    endtask

    // Waits for the next done and checks it against what the model says transaction t should produce.
    task automatic completeTxn(input txn_t t);
        int waited = 0;
        int nBeats;
        int got;
        logic [LW*DW-1:0] expLine;
        while (!bus.i_done && !bus.d_done && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.i_done && !bus.d_done) begin
            checkOutput("doneWithinBudget", 0, 1);
            doReset();
            return;
        end
        nBeats = t.we ? 1 : LW;
        got    = beatLog.size() - beatStart;
        checkOutput("doneOwner", {bus.i_done, bus.d_done}, t.isD ? 2'b01 : 2'b10);
        checkOutput("errOnDone", bus.err, 0);
        checkOutput("beatCount", got, nBeats);
        checkOutput("stableWhileStalled", stabilityErrs, 0);
        for (int k = 0; k < nBeats && k < got; k++) begin
            checkOutput("beatAddr", beatLog[beatStart+k].addr, (int'(t.addr) + k) % MEMSZ);
            checkOutput("beatWe", beatLog[beatStart+k].we, t.we);
            if (t.we) checkOutput("beatWdata", beatLog[beatStart+k].wdata, t.wdata);
        end
        if (t.we) begin
            refMem[t.addr] = t.wdata;
        end else begin
            expLine = expectedLine(t.addr);
            if (t.isD) lastDLine = expLine;
            else       lastILine = expLine;
        end
        checkOutput("iLine", bus.i_line, lastILine);
        checkOutput("dLine", bus.d_line, lastDLine);
        lastWasD  = t.isD;
        beatStart = beatLog.size();
        if (t.isD) bus.d_req = 1'b0;
        else       bus.i_req = 1'b0;
        @(negedge clk);
        checkOutput("donePulseWidth", {bus.i_done, bus.d_done, bus.err}, 0);
    endtask

    task automatic runRound(input bit useI, input bit useD, input txn_t ti, input txn_t td);
        @(negedge clk);
        if (useI) applyStimulus(ti);
        if (useD) applyStimulus(td);
        if (useI && useD) begin
            if (lastWasD) begin
                completeTxn(ti);
                completeTxn(td);
            end else begin
                completeTxn(td);
                completeTxn(ti);
            end
        end else if (useI) completeTxn(ti);
        else if (useD)     completeTxn(td);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        txn_t ti, td;
        bit   sawDone;
        for (int a = 0; a < MEMSZ; a++) refMem[a] = initWord(a);
        reset       = 1'b1;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        readyMode   = 0;
        doReset();

        $display("[TB] line read at 0x010 with memory always ready");
        @(negedge clk);
        ti = '{0, 0, 10'h010, 32'h0};
        applyStimulus(ti);
        for (int n = 1; n <= LW; n++) begin
            @(negedge clk);
            checkOutput("t1 mem_en", bus.mem_en, 1);
            checkOutput("t1 mem_addr", bus.mem_addr, 32'h010 + n - 1);
            checkOutput("t1 early done", bus.i_done, 0);
        end
        @(negedge clk);
        checkOutput("t1 i_done", bus.i_done, 1);
        checkOutput("t1 mem_en off", bus.mem_en, 0);
        completeTxn(ti);

        $display("[TB] write to 0x3FF with three wait cycles");
        @(negedge clk);
        stallBudget = stallUsed + 3;
        td = '{1, 1, 10'h3FF, 32'hDEADBEEF};
        applyStimulus(td);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            checkOutput("t2 mem_en", bus.mem_en, 1);
            checkOutput("t2 mem_addr", bus.mem_addr, 10'h3FF);
            checkOutput("t2 mem_we", bus.mem_we, 1);
            checkOutput("t2 mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        end
        @(negedge clk);
        checkOutput("t2 d_done", bus.d_done, 1);
        checkOutput("t2 mem_en off", bus.mem_en, 0);
        completeTxn(td);

        $display("[TB] simultaneous requests after reset");
        doReset();
        runRound(1, 1, '{0, 0, 10'h020, 32'h0}, '{1, 0, 10'h024, 32'h0});
        runRound(1, 1, '{0, 0, 10'h028, 32'h0}, '{1, 1, 10'h021, 32'h12345678});

        $display("[TB] line read wrapping the top of memory");
        runRound(1, 0, '{0, 0, 10'h3FE, 32'h0}, td);
        runRound(0, 1, ti, '{1, 0, 10'h3FD, 32'h0});

        $display("[TB] reset in the middle of a burst");
        @(negedge clk);
        applyStimulus('{0, 0, 10'h100, 32'h0});
        repeat (3) @(negedge clk);
        checkOutput("t5 beat2 addr", bus.mem_addr, 10'h102);
        reset     = 1'b1;
        bus.i_req = 1'b0;
        #1;
        checkOutput("t5 mem_en at reset", bus.mem_en, 0);
        @(negedge clk);
        reset     = 1'b0;
        lastWasD  = 0;
        lastILine = '0;
        lastDLine = '0;
        sawDone   = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.i_done || bus.d_done) sawDone = 1;
        end
        checkOutput("t5 no done after abort", sawDone, 0);
        beatStart = beatLog.size();
        runRound(1, 0, '{0, 0, 10'h200, 32'h0}, td);

        $display("[TB] memory never ready");
        @(negedge clk);
        readyMode = 2;
        td = '{1, 0, 10'h050, 32'h0};
        applyStimulus(td);
`ifdef ARB_TIMEOUT_EN
        begin
            int n;
            n = 0;
            while (!bus.d_done && n < TIMEOUT_CYCLES + 45) begin
                @(negedge clk);
                n++;
            end
            checkOutput("t6 timeout latency", n, TIMEOUT_CYCLES + 1);
            checkOutput("t6 err with done", {bus.d_done, bus.err}, 2'b11);
            checkOutput("t6 d_line kept", bus.d_line, lastDLine);
            bus.d_req = 1'b0;
            lastWasD  = 1;
            beatStart = beatLog.size();
            readyMode = 1;
            @(negedge clk);
            checkOutput("t6 err pulse width", bus.err, 0);
        end
`else
        sawDone = 0;
        repeat (TIMEOUT_CYCLES + 45) begin
            @(negedge clk);
            if (bus.d_done || bus.err) sawDone = 1;
        end
        checkOutput("t6 no done without timeout", sawDone, 0);
        checkOutput("t6 still bursting", bus.mem_en, 1);
        readyMode = 1;
        doReset();
`endif

        $display("[TB] randomized traffic");
        readyMode = 1;
        for (int r = 0; r < 30; r++) begin
            int mode;
            mode = $urandom_range(0, 2);
            runRound(mode != 1, mode != 0, randTxn(0), randTxn(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single 32-bit data-memory port between the instruction-cache refill path and the data-cache controller. Grants one requester at a time with round-robin fairness. Sequences multi-beat line reads (one 128-bit line = 4 memory words) and single-word writes (write-through / write-around) over the memory's ready handshake. Returns a one-cycle done pulse with the assembled line. Sits between both cache controllers and the data memory.

## Interface
- ADDR_WIDTH, 10, word address width (1024-word memory)
- DATA_WIDTH, 32, memory word width
- LINE_WORDS, 4, words per cache line (line = DATA_WIDTH*LINE_WORDS = 128 bits)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  icache line-read request, held until i_done
- i_addr  in  ADDR_WIDTH  line base word address, held with i_req
- i_line  out  DATA_WIDTH*LINE_WORDS  assembled line, word 0 in LSBs, valid while i_done
- i_done  out  1  one-cycle completion pulse
- d_req  in  1  dcache request, held until d_done
- d_we  in  1  1 = single-word write, 0 = line read
- d_addr  in  ADDR_WIDTH  word address (write) / line base (read)
- d_wdata  in  DATA_WIDTH  write data
- d_line  out  DATA_WIDTH*LINE_WORDS  assembled line for dcache reads
- d_done  out  1  one-cycle completion pulse
- err  out  1  pulses with done on timeout abort; constant 0 without ARB_TIMEOUT_EN
- mem_en  out  1  memory access request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory word address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  read data, valid in the cycle mem_ready=1
- mem_ready  in  1  beat accept/complete from memory

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if any request is high, arbitrate, latch owner, addr, we, wdata, clear beat counter, go to BUSY.
- Arbitration: if only one requester is high, it wins. If both are high, the requester not granted last wins. After reset, "last granted" = I, so D wins the first tie.
- BUSY:
  - mem_en=1; mem_we = latched we.
  - mem_addr = base + beat, truncated modulo 2^ADDR_WIDTH, so addresses wrap at the top of memory.
  - A beat completes on an edge with mem_en & mem_ready. On a read, mem_rdata is stored into line word [beat].
  - Write: 1 beat. Read: LINE_WORDS beats, back-to-back; mem_en stays high between beats.
  - After the last beat, go to RESP.
- RESP: owner's done=1 and its line output is valid; mem_en=0; no arbitration; next state IDLE.
- Requester drops req in the cycle after done. A req still high in IDLE is treated as a new request.
- A request arriving while the other requester is served waits; it is never dropped.
- i_line/d_line hold their last value until overwritten by that requester's next read.
- Reset (any time, including mid-burst):
  - state=IDLE, last granted=I, beat=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - i_done=0, d_done=0, err=0, i_line=0, d_line=0.
  - No done is issued for the aborted transaction.

## Timing
- All outputs are registered.
- Request sampled at edge k, mem_ready tied 1:
  - mem_en high in cycles k+1 .. k+LINE_WORDS.
  - done high in cycle k+LINE_WORDS+1 for a read, k+2 for a write.
- Each mem_ready wait cycle adds exactly one cycle of latency.
- mem_addr, mem_we and mem_wdata are stable while mem_en=1 and mem_ready=0.
- Minimum spacing between two grants: one IDLE cycle after RESP.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit wait counter resets on every accepted beat and counts cycles in BUSY with mem_ready=0.
  - When it reaches TIMEOUT_CYCLES (255), the transaction aborts to RESP: owner's done=1 and err=1; partial line words keep whatever was captured.
- ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; err tied 0.

## Structure
- Package mem_arb_pkg:
  - state enum (IDLE, BUSY, RESP)
  - owner encoding (OWN_I=0, OWN_D=1)
  - TIMEOUT_CYCLES=255
  - LINE_WORDS default
- Sub-module rr_arbiter2: two-request round-robin pick with last-grant register, updated on grant; instantiated once.

## Test plan
- Reset, mem_ready=1, i_req=1 with i_addr=0x010 at cycle 0 -> mem_addr 0x010..0x013 in cycles 1-4, i_done=1 in cycle 5, i_line = {mem[0x013],...,mem[0x010]}.
- d_req=1, d_we=1, d_addr=0x3FF, d_wdata=0xDEADBEEF, mem_ready low for 3 cycles -> mem_en held 4 cycles with stable addr/data, d_done 1 cycle after accept, err=0.
- i_req and d_req rise in the same cycle after reset -> D served first, then I; next simultaneous pair -> D first again (last grant = I).
- Line read at base 0x3FE -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
- reset asserted during beat 2 of a read -> mem_en=0 immediately, no done; a new i_req after release completes normally.
- ARB_TIMEOUT_EN defined, mem_ready stuck 0 -> done and err pulse together 255 cycles after the last accepted beat; without the macro, no done and err stays 0.
